alu_arbiter: RTL and testbench

- Shares the single EX-stage ALU between two requesters: port 0 is the pipeline EX issue, port 1 is the debug/test unit.
- Each request (operands, op, shamt) is accepted over a valid/ready handshake and registered onto the ALU inputs.
- The ALU result and zero flag are captured one cycle later and returned to the winning requester over a valid/ready response handshake.
- Arbitration is round-robin by default.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares the single EX-stage ALU between the pipeline issue port (0)
// and the debug/test port (1). One transaction in flight: IDLE -> EXEC -> RESP.
// Ties go round-robin by default; defining ALU_ARB_FIXED_PRIO_EN makes port 0
// always win ties and removes the last-grant pointer.
module alu_arbiter #(
  parameter int BITS_SIZE  = 32,
  parameter int BITS_SHAMT = 5,
  parameter int BITS_OP    = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // request port 0 (pipeline EX issue)
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [BITS_SIZE-1:0]  i_req0_data_a,
  input  logic [BITS_SIZE-1:0]  i_req0_data_b,
  input  logic [BITS_OP-1:0]    i_req0_op,
  input  logic [BITS_SHAMT-1:0] i_req0_shamt,
  input  logic                  i_req0_flag_shamt,
  // request port 1 (debug/test unit)
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [BITS_SIZE-1:0]  i_req1_data_a,
  input  logic [BITS_SIZE-1:0]  i_req1_data_b,
  input  logic [BITS_OP-1:0]    i_req1_op,
  input  logic [BITS_SHAMT-1:0] i_req1_shamt,
  input  logic                  i_req1_flag_shamt,
  // ALU side
  output logic [BITS_SIZE-1:0]  o_alu_data_a,
  output logic [BITS_SIZE-1:0]  o_alu_data_b,
  output logic [BITS_OP-1:0]    o_alu_op,
  output logic [BITS_SHAMT-1:0] o_alu_shamt,
  output logic                  o_alu_flag_shamt,
  input  logic [BITS_SIZE-1:0]  i_alu_result,
  input  logic                  i_alu_zero,
  // responses (payload shared, valid per port)
  output logic                  o_rsp0_valid,
  output logic                  o_rsp1_valid,
  input  logic                  i_rsp0_ready,
  input  logic                  i_rsp1_ready,
  output logic [BITS_SIZE-1:0]  o_rsp_result,
  output logic                  o_rsp_zero
);

  typedef struct packed {
    logic [BITS_SIZE-1:0]  data_a;
    logic [BITS_SIZE-1:0]  data_b;
    logic [BITS_OP-1:0]    op;
    logic [BITS_SHAMT-1:0] shamt;
    logic                  flag_shamt;
  } alu_req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  alu_req_t [1:0] req;
  alu_req_t       alu_q;
  logic [1:0]     req_valid;
  logic [1:0]     rsp_ready;
  logic [1:0]     rsp_valid;
  logic           sel;       // port that would be granted this cycle
  logic           gnt_port;  // port owning the in-flight transaction
  logic           hs;        // request handshake
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic           last_gnt;
`endif

  assign req[0] = {i_req0_data_a, i_req0_data_b, i_req0_op, i_req0_shamt, i_req0_flag_shamt};
  assign req[1] = {i_req1_data_a, i_req1_data_b, i_req1_op, i_req1_shamt, i_req1_flag_shamt};

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

  // Grant select: a lone requester wins; on a tie the policy decides.
  always_comb begin
    sel = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    sel = ~req_valid[0];
`else
    if (&req_valid) sel = ~last_gnt;
    else            sel = ~req_valid[0];
`endif
  end

  // Readies are only ever offered in IDLE, and only to the selected valid port.
  assign hs           = (state == IDLE) && req_valid[sel];
  assign o_req0_ready = hs && !sel;
  assign o_req1_ready = hs &&  sel;

  assign o_alu_data_a     = alu_q.data_a;
  assign o_alu_data_b     = alu_q.data_b;
  assign o_alu_op         = alu_q.op;
  assign o_alu_shamt      = alu_q.shamt;
  assign o_alu_flag_shamt = alu_q.flag_shamt;

  assign o_rsp0_valid = rsp_valid[0];
  assign o_rsp1_valid = rsp_valid[1];

  // Transaction FSM: latch operands, capture ALU output, hold response until taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      alu_q        <= '0;
      gnt_port     <= 1'b0;
      rsp_valid    <= '0;
      o_rsp_result <= '0;
      o_rsp_zero   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_gnt     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            alu_q    <= req[sel];
            gnt_port <= sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_gnt <= sel;
`endif
            state    <= EXEC;
          end
        end
        EXEC: begin
          o_rsp_result        <= i_alu_result;
          o_rsp_zero          <= i_alu_zero;
          rsp_valid[gnt_port] <= 1'b1;
          state               <= RESP;
        end
        RESP: begin
          // the other port's ready is deliberately ignored
          if (rsp_ready[gnt_port]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random + directed checks of alu_arbiter against a grant/result
// reference model; a behavioural ALU closes the loop on the o_alu_* outputs.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int SW = 5;
  localparam int OW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    rq_v, rs_rdy;
  logic [W-1:0]  ra [2];
  logic [W-1:0]  rb [2];
  logic [OW-1:0] rop [2];
  logic [SW-1:0] rsh [2];
  logic [1:0]    rfl;
  logic          rdy0, rdy1, rsp0_v, rsp1_v;
  logic [W-1:0]  alu_a, alu_b, alu_result, rsp_result;
  logic [OW-1:0] alu_op;
  logic [SW-1:0] alu_sh;
  logic          alu_fl, alu_zero, rsp_zero;
  wire  [1:0]    rq_rdy = {rdy1, rdy0};
  wire  [1:0]    rs_v   = {rsp1_v, rsp0_v};

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_last;   // model: port granted last (1 after reset)

  alu_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(rq_v[0]), .o_req0_ready(rdy0),
    .i_req0_data_a(ra[0]), .i_req0_data_b(rb[0]), .i_req0_op(rop[0]),
    .i_req0_shamt(rsh[0]), .i_req0_flag_shamt(rfl[0]),
    .i_req1_valid(rq_v[1]), .o_req1_ready(rdy1),
    .i_req1_data_a(ra[1]), .i_req1_data_b(rb[1]), .i_req1_op(rop[1]),
    .i_req1_shamt(rsh[1]), .i_req1_flag_shamt(rfl[1]),
    .o_alu_data_a(alu_a), .o_alu_data_b(alu_b), .o_alu_op(alu_op),
    .o_alu_shamt(alu_sh), .o_alu_flag_shamt(alu_fl),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero),
    .o_rsp0_valid(rsp0_v), .o_rsp1_valid(rsp1_v),
    .i_rsp0_ready(rs_rdy[0]), .i_rsp1_ready(rs_rdy[1]),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero)
  );

  // Behavioural MIPS-style ALU: returns {zero, result}; unknown ops give all ones.
  function automatic logic [W:0] ref_alu(input logic [OW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [SW-1:0] sh,
                                         input logic fl);
    logic [SW-1:0] s;
    logic [W-1:0]  r;
    s = fl ? sh : a[SW-1:0];
    case (op)
      6'b100000, 6'b100001: r = a + b;
      6'b100010, 6'b100011: r = a - b;
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b101010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b000000: r = b << s;
      6'b000010: r = b >> s;
      6'b000011: r = $signed(b) >>> s;
      default:   r = '1;
    endcase
    return {(r == '0), r};
  endfunction

  always_comb {alu_zero, alu_result} = ref_alu(alu_op, alu_a, alu_b, alu_sh, alu_fl);

  wire [112:0] all_out = {alu_a, alu_b, alu_op, alu_sh, alu_fl, rs_v, rq_rdy, rsp_result, rsp_zero};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rq_v = '0; rs_rdy = '0; rst_n = 1'b0;
    #12;
    @(negedge clk) rst_n = 1'b1;
    exp_last = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OW-1:0] op, input logic [SW-1:0] sh, input logic fl);
    ra[p] = a; rb[p] = b; rop[p] = op; rsh[p] = sh; rfl[p] = fl; rq_v[p] = 1'b1;
  endtask

  // Waits for response on port p (entered just after an edge); returns edges waited.
  task automatic wait_rsp(input int p, output int lat, output bit tmo);
    lat = 1; tmo = 0;
    @(negedge clk);
    while (!rs_v[p] && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    if (!rs_v[p]) tmo = 1;
  endtask

  task automatic consume(input int p);
    rs_rdy[p] = 1'b1;
    @(posedge clk); #1 rs_rdy[p] = 1'b0;
  endtask

  // Single-port transaction; reports result, edges from ready-cycle to rsp valid, timeout.
  task automatic run_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [OW-1:0] op, input logic [SW-1:0] sh, input logic fl,
                        output logic [W-1:0] res, output logic z, output int lat, output bit tmo);
    int n;
    bit t2;
    issue(p, a, b, op, sh, fl);
    n = 0;
    @(negedge clk);
    while (!rq_rdy[p] && n < 20) begin @(negedge clk); n++; end
    tmo = !rq_rdy[p];
    @(posedge clk); #1 rq_v[p] = 1'b0;
    exp_last = p[0];
    wait_rsp(p, lat, t2);
    tmo = tmo | t2;
    res = rsp_result; z = rsp_zero;
    consume(p);
  endtask

  task automatic test_reset();
    rq_v = '0; rs_rdy = '0; rst_n = 1'b0;
    #3;
    n_chk++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(negedge clk) rst_n = 1'b1;
    exp_last = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_release_idle: got %h want 0", all_out); end
  endtask

  task automatic test_single();
    logic [W-1:0] res; logic z; int lat; bit tmo;
    run_op(0, 32'd5, 32'd3, 6'b100000, 5'd0, 1'b0, res, z, lat, tmo);
    n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got timeout"); end
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", lat); end
    n_chk++; if ({z, res} !== {1'b0, 32'd8}) begin n_fail++; $display("FAIL single_add: got %h z=%b want 8 z=0", res, z); end
  endtask

  task automatic test_both();
    int lat, n, g, e; bit tmo;
    logic [W:0] want;
    apply_reset();
    issue(0, 32'd7, 32'd7, 6'b100010, 5'd0, 1'b0);
    issue(1, 32'hF0, 32'h0F, 6'b100101, 5'd0, 1'b0);
    @(negedge clk);
    n_chk++; if (rq_rdy !== 2'b01) begin n_fail++; $display("FAIL both_first_grant: got %b want 01", rq_rdy); end
    @(posedge clk); #1 rq_v[0] = 1'b0;
    wait_rsp(0, lat, tmo);
    n_chk++; if ({tmo, rs_v, rsp_zero, rsp_result} !== {1'b0, 2'b01, 1'b1, 32'd0})
      begin n_fail++; $display("FAIL both_rsp0: got tmo=%b v=%b z=%b r=%h want 0 01 1 0", tmo, rs_v, rsp_zero, rsp_result); end
    consume(0);
    @(negedge clk);
    n_chk++; if (rq_rdy !== 2'b10) begin n_fail++; $display("FAIL both_second_grant: got %b want 10", rq_rdy); end
    @(posedge clk); #1 rq_v[1] = 1'b0;
    wait_rsp(1, lat, tmo);
    n_chk++; if ({tmo, rs_v, rsp_zero, rsp_result} !== {1'b0, 2'b10, 1'b0, 32'h0000_00FF})
      begin n_fail++; $display("FAIL both_rsp1: got tmo=%b v=%b z=%b r=%h want 0 10 0 ff", tmo, rs_v, rsp_zero, rsp_result); end
    consume(1);
    exp_last = 1'b1;
    // both held valid across several grants: alternation (or starvation of port 1)
    rq_v = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = exp_last ? 0 : 1;
`endif
      n = 0;
      @(negedge clk);
      while (rq_rdy == 2'b00 && n < 20) begin @(negedge clk); n++; end
      n_chk++; if (rq_rdy !== (2'b01 << e)) begin n_fail++; $display("FAIL both_held_grant%0d: got %b want %b", k, rq_rdy, 2'b01 << e); end
      g = e;
      exp_last = g[0];
      @(posedge clk); #1;
      wait_rsp(g, lat, tmo);
      want = (g == 0) ? {1'b1, 32'd0} : {1'b0, 32'hFF};
      n_chk++; if ({tmo, rsp_zero, rsp_result} !== {1'b0, want}) begin n_fail++; $display("FAIL both_held_rsp%0d: got tmo=%b z=%b r=%h want %h", k, tmo, rsp_zero, rsp_result, want); end
      consume(g);
    end
    rq_v = 2'b00;
  endtask

  task automatic test_shift();
    logic [W-1:0] res; logic z; int lat; bit tmo;
    run_op(1, 32'd0, 32'd1, 6'b000000, 5'd4, 1'b1, res, z, lat, tmo);
    n_chk++; if ({tmo, z, res} !== {1'b0, 1'b0, 32'd16}) begin n_fail++; $display("FAIL shift_sll: got tmo=%b z=%b r=%h want 10", tmo, z, res); end
    run_op(1, 32'd0, 32'h8000_0000, 6'b000011, 5'd4, 1'b1, res, z, lat, tmo);
    n_chk++; if ({tmo, z, res} !== {1'b0, 1'b0, 32'hF800_0000}) begin n_fail++; $display("FAIL shift_sra: got tmo=%b z=%b r=%h want f8000000", tmo, z, res); end
    // flag low: shift amount comes from A[4:0], shamt ignored
    run_op(1, 32'd3, 32'd5, 6'b000000, 5'd9, 1'b0, res, z, lat, tmo);
    n_chk++; if ({tmo, z, res} !== {1'b0, 1'b0, 32'd40}) begin n_fail++; $display("FAIL shift_from_a: got tmo=%b z=%b r=%h want 28", tmo, z, res); end
  endtask

  task automatic test_backpressure();
    int lat; bit tmo;
    issue(0, 32'd10, 32'd20, 6'b100000, 5'd0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rq_v[0] = 1'b0;
    exp_last = 1'b0;
    wait_rsp(0, lat, tmo);
    n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_timeout: got timeout"); end
    issue(1, 32'h1234, 32'h00FF, 6'b100110, 5'd0, 1'b0);
    rs_rdy[1] = 1'b1;   // wrong port's ready must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++; if ({rs_v, rq_rdy, rsp_result} !== {2'b01, 2'b00, 32'd30})
        begin n_fail++; $display("FAIL bp_hold%0d: got v=%b rdy=%b r=%h want 01 00 1e", i, rs_v, rq_rdy, rsp_result); end
    end
    rs_rdy[1] = 1'b0;
    consume(0);
    @(negedge clk);
    n_chk++; if ({rs_v, rq_rdy} !== {2'b00, 2'b10}) begin n_fail++; $display("FAIL bp_next_accept: got v=%b rdy=%b want 00 10", rs_v, rq_rdy); end
    @(posedge clk); #1 rq_v[1] = 1'b0;
    exp_last = 1'b1;
    wait_rsp(1, lat, tmo);
    n_chk++; if ({tmo, rsp_result} !== {1'b0, 32'h12CB}) begin n_fail++; $display("FAIL bp_second_rsp: got tmo=%b r=%h want 12cb", tmo, rsp_result); end
    consume(1);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res; logic z; int lat; bit tmo; bit seen;
    issue(0, 32'd100, 32'd1, 6'b100010, 5'd0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rq_v[0] = 1'b0;   // now in EXEC
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (all_out !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", all_out); end
    @(negedge clk) rst_n = 1'b1;
    exp_last = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rs_v != 2'b00) seen = 1; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_rsp: got response after reset, want none"); end
    @(posedge clk); #1;
    run_op(0, 32'd100, 32'd1, 6'b100010, 5'd0, 1'b0, res, z, lat, tmo);
    n_chk++; if ({tmo, z, res} !== {1'b0, 1'b0, 32'd99}) begin n_fail++; $display("FAIL midreset_recover: got tmo=%b z=%b r=%h want 63", tmo, z, res); end
  endtask

  task automatic test_illegal();
    logic [W-1:0] res; logic z; int lat; bit tmo;
    run_op(0, $urandom, $urandom, 6'b111111, 5'($urandom), 1'($urandom), res, z, lat, tmo);
    n_chk++; if ({tmo, z, res} !== {1'b0, 1'b0, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL illegal_op: got tmo=%b z=%b r=%h want ffffffff z=0", tmo, z, res); end
  endtask

  task automatic test_random();
    logic [OW-1:0] ops [13];
    logic [1:0] pend;
    logic [W:0] want;
    int n, e, lat, d; bit tmo;
    ops = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
            6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011, 6'b111111};
    for (int it = 0; it < 40; it++) begin
      pend = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) if (pend[p]) begin
        ra[p] = $urandom; rb[p] = ($urandom_range(0, 3) == 0) ? ra[p] : $urandom;
        rop[p] = ops[$urandom_range(0, 12)]; rsh[p] = 5'($urandom); rfl[p] = 1'($urandom);
      end
      rq_v = pend;
      while (pend != 2'b00) begin
        if (pend == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          e = 0;
`else
          e = exp_last ? 0 : 1;
`endif
        end else e = pend[1] ? 1 : 0;
        n = 0;
        @(negedge clk);
        while (rq_rdy == 2'b00 && n < 20) begin @(negedge clk); n++; end
        n_chk++; if (rq_rdy !== (2'b01 << e)) begin n_fail++; $display("FAIL rand_grant it%0d: got %b want %b", it, rq_rdy, 2'b01 << e); end
        want = ref_alu(rop[e], ra[e], rb[e], rsh[e], rfl[e]);
        @(posedge clk); #1 rq_v[e] = 1'b0;
        pend[e] = 1'b0;
        exp_last = e[0];
        wait_rsp(e, lat, tmo);
        n_chk++; if ({tmo, lat[1:0], rs_v, rsp_zero, rsp_result} !== {1'b0, 2'd2, 2'b01 << e, want})
          begin n_fail++; $display("FAIL rand_rsp it%0d: got tmo=%b lat=%0d v=%b z=%b r=%h want lat=2 v=%b %h", it, tmo, lat, rs_v, rsp_zero, rsp_result, 2'b01 << e, want); end
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin rs_rdy[1-e] = 1'($urandom); @(posedge clk); #1; end
        rs_rdy[1-e] = 1'b0;
        @(negedge clk);
        n_chk++; if ({rs_v, rsp_zero, rsp_result} !== {2'b01 << e, want}) begin n_fail++; $display("FAIL rand_hold it%0d: got v=%b z=%b r=%h want %h", it, rs_v, rsp_zero, rsp_result, want); end
        consume(e);
      end
    end
  endtask

  initial begin
    rq_v = '0; rs_rdy = '0; rfl = '0; rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin ra[p] = '0; rb[p] = '0; rop[p] = '0; rsh[p] = '0; end
    test_reset();
    test_single();
    test_both();
    test_shift();
    test_backpressure();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
